// File: rtl/sprite_unit_dbuf_pkg.sv
// Shared types for the sprite engine: sprite configuration, output pixel and limits.
package sprite_unit_dbuf_pkg;

  localparam int SPR_PIX_BITS        = 4;
  localparam int SPR_MAX_TILES_LIMIT = 8;

  typedef struct packed {
    logic [8:0] x;
    logic [2:0] w;
    logic       x_mirror;
    logic [4:0] palette;
    logic       fg_prio;
    logic       bg_prio;
  } sprite_conf_t;

  typedef struct packed {
    logic [4:0]              palette;
    logic [SPR_PIX_BITS-1:0] pixel;
    logic                    fg_prio;
    logic                    bg_prio;
    logic                    transparent;
  } sprite_pixel_t;

  localparam sprite_pixel_t PIXEL_IDLE = '{
    palette: 5'd0, pixel: '0, fg_prio: 1'b0, bg_prio: 1'b0, transparent: 1'b1
  };

endpackage

// File: rtl/sprite_pixel_sel.sv
// Combinational pixel picker: clamps sprite width, tests the column span,
// applies mirroring and decides transparency for one sprite row.
module sprite_pixel_sel
  import sprite_unit_dbuf_pkg::*;
#(
  parameter int PIX_BITS  = 4,
  parameter int MAX_TILES = 4,
  parameter int COL_W     = 9,
  localparam int PAT_W    = MAX_TILES * 8 * PIX_BITS
) (
  input  sprite_conf_t         conf,
  input  logic                 conf_valid,
  input  logic [PAT_W-1:0]     pat,
  input  logic [COL_W-1:0]     col,
  output sprite_pixel_t        pix
);

  localparam int IDX_W = $clog2(MAX_TILES * 8);
  localparam int SH_W  = $clog2(PAT_W) + 1;

  logic [3:0]       weff;
  logic [COL_W:0]   x_ext;
  logic [COL_W:0]   col_ext;
  logic [COL_W:0]   span_end;
  logic [IDX_W-1:0] off;
  logic [IDX_W-1:0] width_m1;
  logic [IDX_W-1:0] idx;
  logic [SH_W-1:0]  shamt;
  logic [PIX_BITS-1:0] value;
  logic             in_span;

  always_comb begin
    if (conf.w == 3'd0)
      weff = 4'd0;
    else if ({1'b0, conf.w} > 4'(MAX_TILES))
      weff = 4'(MAX_TILES);
    else
      weff = {1'b0, conf.w};

    // One extra bit keeps a sprite near the right edge from wrapping to column 0.
    x_ext    = (COL_W+1)'(conf.x);
    col_ext  = {1'b0, col};
    span_end = x_ext + (COL_W+1)'({weff, 3'b000});
    in_span  = conf_valid && (weff != 4'd0) && (col_ext >= x_ext) && (col_ext < span_end);

    // Index arithmetic is modular in IDX_W bits; the result is exact inside the span.
    off      = IDX_W'(col_ext - x_ext);
    width_m1 = IDX_W'({weff, 3'b000} - 7'd1);
    idx      = conf.x_mirror ? (width_m1 - off) : off;
    shamt    = SH_W'(idx) * SH_W'(PIX_BITS);
    value    = PIX_BITS'(pat >> shamt);

    pix             = PIXEL_IDLE;
    pix.palette     = conf.palette;
    pix.fg_prio     = conf.fg_prio;
    pix.bg_prio     = conf.bg_prio;
    pix.pixel       = in_span ? SPR_PIX_BITS'(value) : '0;
    pix.transparent = !in_span || (value == '0);
  end

endmodule

// File: rtl/sprite_unit_dbuf.sv
// Double-buffered sprite unit: shadow register rides the left-stealing chain,
// active register drives the registered pixel; line_start swaps them.
module sprite_unit_dbuf
  import sprite_unit_dbuf_pkg::*;
#(
  parameter int PIX_BITS  = 4,
  parameter int MAX_TILES = 4,
  parameter int COL_W     = 9,
  localparam int PAT_W    = MAX_TILES * 8 * PIX_BITS
) (
  input  logic             clock,
  input  logic             reset_l,
  input  logic             clear,
  input  logic             line_start,
  input  sprite_conf_t     in_conf,
  input  logic [PAT_W-1:0] in_pat,
  input  logic             in_valid,
  output logic             in_ack,
  output sprite_conf_t     out_conf,
  output logic [PAT_W-1:0] out_pat,
  output logic             out_valid,
  input  logic             out_ack,
  input  logic [COL_W-1:0] col,
  output sprite_pixel_t    pixel
);

  sprite_conf_t     sh_conf, act_conf;
  logic [PAT_W-1:0] sh_pat, act_pat;
  logic             sh_valid, act_valid;
  sprite_pixel_t    pixel_q, sel_pix;
  logic             drain;

  assign drain = out_ack & sh_valid;

  // Gated by reset_l so the handshake stays quiet while reset is held.
  assign in_ack    = reset_l & in_valid & ~sh_valid & ~clear & ~line_start & ~drain;
  assign out_valid = reset_l & sh_valid & ~clear & ~line_start;
  assign out_conf  = sh_conf;
  assign out_pat   = sh_pat;
  assign pixel     = pixel_q;

  always_ff @(posedge clock or negedge reset_l) begin
    if (!reset_l) begin
      sh_conf   <= '0;
      sh_pat    <= '0;
      sh_valid  <= 1'b0;
      act_conf  <= '0;
      act_pat   <= '0;
      act_valid <= 1'b0;
    end else if (clear) begin
      sh_valid  <= 1'b0;
      act_valid <= 1'b0;
    end else if (line_start) begin
      act_conf  <= sh_conf;
      act_pat   <= sh_pat;
      act_valid <= sh_valid;
      sh_valid  <= 1'b0;
    end else if (drain) begin
      sh_valid  <= 1'b0;
    end else if (in_valid && !sh_valid) begin
      sh_conf   <= in_conf;
      sh_pat    <= in_pat;
      sh_valid  <= 1'b1;
    end
  end

  sprite_pixel_sel #(
    .PIX_BITS  (PIX_BITS),
    .MAX_TILES (MAX_TILES),
    .COL_W     (COL_W)
  ) u_sel (
    .conf       (act_conf),
    .conf_valid (act_valid),
    .pat        (act_pat),
    .col        (col),
    .pix        (sel_pix)
  );

  // A clear blanks the output on the very next cycle rather than one later.
  always_ff @(posedge clock or negedge reset_l) begin
    if (!reset_l)
      pixel_q <= PIXEL_IDLE;
    else if (clear)
      pixel_q <= PIXEL_IDLE;
    else
      pixel_q <= sel_pix;
  end

endmodule
